// File: rtl/beam_delay_pkg.sv
// beam_delay_pkg: shared state encoding, default sizing and width constants
// for the beam_delay_array block.
package beam_delay_pkg;

   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_NUM_CHANNELS = 16;
   localparam int DEF_MAX_DELAY    = 256;

   localparam int DELAY_W = $clog2(DEF_MAX_DELAY);
   localparam int CH_W    = $clog2(DEF_NUM_CHANNELS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } bda_state_e;

endpackage

// File: rtl/delay_ring_mem.sv
// delay_ring_mem: one channel's sample history ring. One synchronous write
// port, one asynchronous read port so a tap can be loaded into the output
// register in the same cycle as the accept.
module delay_ring_mem #(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 256,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // store accepted samples; contents are never reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/beam_delay_array.sv
// beam_delay_array: per-channel programmable sample delay for a beamformer.
// Delays are written into a shadow table and copied to the active table on
// cfg_commit. Output is withheld (PRIME) until enough history exists for the
// largest active delay.
// Optional feature: define BEAM_DELAY_SUM_EN to add m_sum, the registered
// signed sum of all delayed channels.
//
// state | meaning
// IDLE  | no delay table committed yet, input stalled
// PRIME | collecting history, samples stored but not output
// RUN   | every accept produces one delayed output vector
module beam_delay_array
   import beam_delay_pkg::*;
#(
   parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
   parameter  int MAX_DELAY    = DEF_MAX_DELAY,
   localparam int DLY_BITS     = $clog2(MAX_DELAY),
   localparam int CH_BITS      = $clog2(NUM_CHANNELS)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cfg_we,
   input  logic [CH_BITS-1:0]                   cfg_ch,
   input  logic [DLY_BITS-1:0]                  cfg_delay,
   input  logic                                 cfg_commit,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   s_data,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   m_data,
`ifdef BEAM_DELAY_SUM_EN
   output logic signed [DATA_WIDTH+CH_BITS-1:0] m_sum,
`endif
   output logic                                 primed
);

   localparam logic [DLY_BITS:0] FILL_MAX = (DLY_BITS+1)'(MAX_DELAY);

   bda_state_e state_q;
   logic       primed_q;
   logic       m_valid_q;

   logic [DLY_BITS-1:0] wp_q;
   logic [DLY_BITS-1:0] max_q;
   logic [DLY_BITS-1:0] new_max;
   logic [DLY_BITS:0]   fill_q;
   logic [DLY_BITS:0]   fill_d;

   logic [DLY_BITS-1:0] shadow_q [NUM_CHANNELS];
   logic [DLY_BITS-1:0] shadow_d [NUM_CHANNELS];
   logic [DLY_BITS-1:0] active_q [NUM_CHANNELS];
   logic [DLY_BITS-1:0] rd_addr  [NUM_CHANNELS];

   logic [DATA_WIDTH-1:0] rd_data [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0] tap     [NUM_CHANNELS];

   logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_data_q;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_data_d;

   logic cfg_ok;
   logic accept;
   logic out_fire;
   logic deepen;

   // input handshake depends on mode; in RUN only accept when output slot frees
   always_comb begin
      s_ready = 1'b0;
      case (state_q)
         ST_PRIME: s_ready = 1'b1;
         ST_RUN:   s_ready = !m_valid_q || m_ready;
         default:  s_ready = 1'b0;
      endcase
   end

   assign accept   = s_valid && s_ready;
   assign cfg_ok   = cfg_we && (32'(cfg_ch) < 32'(NUM_CHANNELS));
   assign out_fire = accept && ((state_q == ST_RUN) ||
                     ((state_q == ST_PRIME) && (fill_q >= {1'b0, max_q})));
   assign fill_d   = (accept && (fill_q != FILL_MAX)) ? fill_q + (DLY_BITS+1)'(1) : fill_q;
   // a commit needing more history than the next accept will have re-primes
   assign deepen   = {1'b0, new_max} > fill_d;

   // shadow table including a same-cycle write, and its maximum for commit
   always_comb begin
      shadow_d = shadow_q;
      if (cfg_ok) begin
         shadow_d[cfg_ch] = cfg_delay;
      end
      new_max = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (shadow_d[c] > new_max) begin
            new_max = shadow_d[c];
         end
      end
   end

   // per-channel ring and tap select; delay 0 bypasses the ring
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      assign rd_addr[c] = wp_q - active_q[c];

      delay_ring_mem #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (MAX_DELAY)
      ) u_ring (
         .clk     (clk),
         .we_i    (accept),
         .waddr_i (wp_q),
         .wdata_i (s_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .raddr_i (rd_addr[c]),
         .rdata_o (rd_data[c])
      );

      assign tap[c] = (active_q[c] == '0) ? s_data[c*DATA_WIDTH +: DATA_WIDTH] : rd_data[c];
   end

   // next output vector: load taps on an output-producing accept, else hold
   always_comb begin
      m_data_d = m_data_q;
      if (out_fire) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            m_data_d[c*DATA_WIDTH +: DATA_WIDTH] = tap[c];
         end
      end
   end

   // mode sequencing with registered primed flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         primed_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_commit) begin
                  state_q <= ST_PRIME;
               end
            end
            ST_PRIME, ST_RUN: begin
               if (cfg_commit && deepen) begin
                  state_q  <= ST_PRIME;
                  primed_q <= 1'b0;
               end else if (out_fire) begin
                  state_q  <= ST_RUN;
                  primed_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               primed_q <= 1'b0;
            end
         endcase
      end
   end

   // write pointer, history count, delay tables and output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q      <= '0;
         fill_q    <= '0;
         max_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            shadow_q[c] <= '0;
            active_q[c] <= '0;
         end
      end else begin
         if (accept) begin
            wp_q <= wp_q + DLY_BITS'(1);
         end
         fill_q   <= fill_d;
         shadow_q <= shadow_d;
         if (cfg_commit) begin
            active_q <= shadow_d;
            max_q    <= new_max;
         end
         m_valid_q <= out_fire || (m_valid_q && !m_ready);
         m_data_q  <= m_data_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign primed  = primed_q;

`ifdef BEAM_DELAY_SUM_EN
   localparam int SUM_W = DATA_WIDTH + CH_BITS;

   logic signed [SUM_W-1:0] sum_q;
   logic signed [SUM_W-1:0] sum_d;

   // sign-extended sum of the taps being loaded; width cannot overflow
   always_comb begin
      sum_d = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         sum_d = sum_d + SUM_W'($signed(tap[c]));
      end
   end

   // sum register tracks m_data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else if (out_fire) begin
         sum_q <= sum_d;
      end
   end

   assign m_sum = sum_q;
`endif

endmodule

// File: tb/tb_beam_delay_array.sv
// Bench for beam_delay_array: hand-computed vector table, directed corner
// sequences and randomized traffic against a sample-history reference model.
module tb_beam_delay_array;

   localparam int DW  = 16;
   localparam int NC  = 16;
   localparam int MD  = 256;
   localparam int CW  = beam_delay_pkg::CH_W;
   localparam int DLW = beam_delay_pkg::DELAY_W;

   logic clk = 1'b0;
   logic reset, cfg_we, cfg_commit, s_valid, s_ready, m_valid, m_ready, primed;
   logic [CW-1:0]      cfg_ch;
   logic [DLW-1:0]     cfg_delay;
   logic [NC*DW-1:0]   s_data, m_data;
`ifdef BEAM_DELAY_SUM_EN
   logic signed [DW+CW-1:0] m_sum;
`endif

   always #5 clk = ~clk;

   beam_delay_array #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MAX_DELAY(MD)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
      .cfg_commit(cfg_commit), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef BEAM_DELAY_SUM_EN
      .m_sum(m_sum),
`endif
      .primed(primed));

   typedef struct {
      bit rst, sv, mr, we, commit;
      logic [NC*DW-1:0] data;
      int ch, dly;
   } stim_t;

   typedef struct {
      bit rst, sv, mr, we, commit;
      int v, ch, dly;
      bit e_ready, e_valid, e_primed;
      int e0, e1;
   } vec_t;

   int checks = 0;
   int failures = 0;
   logic seen_ready;

   // reference model: absolute sample history plus table/mode bookkeeping
   bit mc_committed, mc_run;
   int mc_fill, mc_max;
   int mc_act[NC];
   int mc_sh[NC];
   logic [NC*DW-1:0] hist[$];
   bit exp_valid, exp_ready;
   logic [NC*DW-1:0] exp_data;

   task automatic chk(input string nm, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mc_committed = 0; mc_run = 0; mc_fill = 0; mc_max = 0;
      for (int c = 0; c < NC; c++) begin mc_act[c] = 0; mc_sh[c] = 0; end
      hist.delete();
      exp_valid = 0; exp_data = '0;
   endtask

   function automatic logic [NC*DW-1:0] splat(input int v);
      logic [NC*DW-1:0] r;
      for (int c = 0; c < NC; c++) r[c*DW +: DW] = DW'(v);
      return r;
   endfunction

   function automatic logic [NC*DW-1:0] rnd_data();
      logic [NC*DW-1:0] r;
      for (int c = 0; c < NC; c++) r[c*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   function automatic stim_t mks(input bit rst, sv, mr, we, cm, input logic [NC*DW-1:0] d,
                                 input int ch, dly);
      stim_t s;
      s.rst = rst; s.sv = sv; s.mr = mr; s.we = we; s.commit = cm;
      s.data = d; s.ch = ch; s.dly = dly;
      return s;
   endfunction

   function automatic vec_t mkv(input bit rst, sv, mr, we, cm, input int v, ch, dly,
                                input bit er, ev, ep, input int e0, e1);
      vec_t t;
      t.rst = rst; t.sv = sv; t.mr = mr; t.we = we; t.commit = cm;
      t.v = v; t.ch = ch; t.dly = dly;
      t.e_ready = er; t.e_valid = ev; t.e_primed = ep; t.e0 = e0; t.e1 = e1;
      return t;
   endfunction

   // one clock cycle: drive, check s_ready before the edge, advance model, check outputs after
   task automatic step(input stim_t st);
      int nsh[NC];
      int nmax, n, fill_nx, d, s;
      bit acc, outp;
      logic [NC*DW-1:0] od, h;
      reset = st.rst; s_valid = st.sv; s_data = st.data; m_ready = st.mr;
      cfg_we = st.we; cfg_ch = CW'(st.ch); cfg_delay = DLW'(st.dly); cfg_commit = st.commit;
      #4;
      if (st.rst || !mc_committed) exp_ready = 0;
      else if (!mc_run) exp_ready = 1;
      else exp_ready = !exp_valid || st.mr;
      seen_ready = s_ready;
      chk("s_ready", {255'b0, s_ready}, {255'b0, exp_ready});
      n = hist.size();
      acc = st.sv && exp_ready;
      nsh = mc_sh;
      if (st.we && st.ch < NC) nsh[st.ch] = st.dly;
      nmax = 0;
      foreach (nsh[c]) if (nsh[c] > nmax) nmax = nsh[c];
      outp = acc && (mc_run || mc_fill >= mc_max);
      od = exp_data;
      if (outp) begin
         for (int c = 0; c < NC; c++) begin
            d = mc_act[c];
            h = (d == 0) ? st.data : hist[n-d];
            od[c*DW +: DW] = h[c*DW +: DW];
         end
      end
      fill_nx = mc_fill + (acc ? 1 : 0);
      if (fill_nx > MD) fill_nx = MD;
      @(posedge clk); #1;
      if (st.rst) begin
         model_reset();
      end else begin
         if (st.commit && mc_committed && nmax > fill_nx) mc_run = 0;
         else if (outp) mc_run = 1;
         if (st.commit) begin mc_committed = 1; mc_act = nsh; mc_max = nmax; end
         mc_sh = nsh;
         mc_fill = fill_nx;
         if (acc) hist.push_back(st.data);
         if (outp) begin exp_valid = 1; exp_data = od; end
         else if (st.mr) exp_valid = 0;
      end
      chk("primed", {255'b0, primed}, {255'b0, mc_run});
      chk("m_valid", {255'b0, m_valid}, {255'b0, exp_valid});
      chk("m_data", m_data, exp_data);
`ifdef BEAM_DELAY_SUM_EN
      s = 0;
      for (int c = 0; c < NC; c++) s += int'($signed(exp_data[c*DW +: DW]));
      chk("m_sum", {236'b0, m_sum}, {236'b0, (DW+CW)'(s)});
`else
      s = 0;
`endif
   endtask

   vec_t tbl[18];
   stim_t st;
   logic [NC*DW-1:0] saved, dd, h;
   int cnt;
   int hn;

   initial begin
      reset = 1; s_valid = 0; s_data = '0; m_ready = 0;
      cfg_we = 0; cfg_ch = '0; cfg_delay = '0; cfg_commit = 0;
      model_reset();

      //          rst sv mr we cm  v  ch dly  rdy val pri e0 e1
      tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0);
      tbl[1]  = mkv(0, 0, 0, 0, 1, 0, 0, 0,   0,  0,  0,  0, 0);
      tbl[2]  = mkv(0, 1, 1, 0, 0, 1, 0, 0,   1,  1,  1,  1, 1);
      tbl[3]  = mkv(0, 1, 1, 0, 0, 2, 0, 0,   1,  1,  1,  2, 2);
      tbl[4]  = mkv(0, 1, 1, 0, 0, 3, 0, 0,   1,  1,  1,  3, 3);
      tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,   0,  1,  1,  3, 3);
      tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,   0,  1,  1,  3, 3);
      tbl[7]  = mkv(1, 0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0);
      tbl[8]  = mkv(0, 0, 0, 1, 0, 0, 1, 3,   0,  0,  0,  0, 0);
      tbl[9]  = mkv(0, 0, 0, 0, 1, 0, 0, 0,   0,  0,  0,  0, 0);
      tbl[10] = mkv(0, 1, 1, 0, 0, 10, 0, 0,  1,  0,  0,  0, 0);
      tbl[11] = mkv(0, 1, 1, 0, 0, 11, 0, 0,  1,  0,  0,  0, 0);
      tbl[12] = mkv(0, 1, 1, 0, 0, 12, 0, 0,  1,  0,  0,  0, 0);
      tbl[13] = mkv(0, 1, 1, 0, 0, 13, 0, 0,  1,  1,  1, 13, 10);
      tbl[14] = mkv(0, 1, 1, 0, 0, 14, 0, 0,  1,  1,  1, 14, 11);
      tbl[15] = mkv(0, 1, 0, 0, 0, 15, 0, 0,  0,  1,  1, 14, 11);
      tbl[16] = mkv(0, 1, 1, 0, 0, 15, 0, 0,  1,  1,  1, 15, 12);
      tbl[17] = mkv(0, 0, 1, 0, 0, 0, 0, 0,   1,  0,  1, 15, 12);

      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) begin
         step(mks(tbl[i].rst, tbl[i].sv, tbl[i].mr, tbl[i].we, tbl[i].commit,
                  splat(tbl[i].v), tbl[i].ch, tbl[i].dly));
         chk($sformatf("tbl%0d_ready", i), {255'b0, seen_ready}, {255'b0, tbl[i].e_ready});
         chk($sformatf("tbl%0d_valid", i), {255'b0, m_valid}, {255'b0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_primed", i), {255'b0, primed}, {255'b0, tbl[i].e_primed});
         chk($sformatf("tbl%0d_ch0", i), {240'b0, m_data[0 +: DW]}, {240'b0, DW'(tbl[i].e0)});
         chk($sformatf("tbl%0d_ch1", i), {240'b0, m_data[DW +: DW]}, {240'b0, DW'(tbl[i].e1)});
      end

      // deepening commit re-primes; delay 200 then 255
      step(mks(1, 0, 0, 0, 0, '0, 0, 0));
      step(mks(0, 0, 1, 0, 1, '0, 0, 0));
      for (int i = 0; i < 4; i++) step(mks(0, 1, 1, 0, 0, rnd_data(), 0, 0));
      step(mks(0, 0, 1, 1, 1, '0, 1, 200));
      chk("d200_primed_drop", {255'b0, primed}, 256'd0);
      cnt = 0;
      while (!primed && cnt < 400) begin
         step(mks(0, 1, 1, 0, 0, rnd_data(), 0, 0));
         cnt++;
      end
      chk("d200_accepts_to_run", 256'(cnt), 256'd197);
      step(mks(0, 0, 1, 1, 1, '0, 1, 255));
      chk("d255_primed_drop", {255'b0, primed}, 256'd0);
      cnt = 0;
      while (!primed && cnt < 400) begin
         step(mks(0, 1, 1, 0, 0, rnd_data(), 0, 0));
         cnt++;
      end
      chk("d255_accepts_to_run", 256'(cnt), 256'd55);
      h = hist[0];
      chk("d255_oldest", {240'b0, m_data[DW +: DW]}, {240'b0, h[DW +: DW]});

      // output back-pressure: stall five cycles, then release
      step(mks(0, 1, 1, 0, 0, rnd_data(), 0, 0));
      saved = m_data;
      dd = rnd_data();
      for (int i = 0; i < 5; i++) begin
         step(mks(0, 1, 0, 0, 0, dd, 0, 0));
         chk("stall_ready", {255'b0, seen_ready}, 256'd0);
         chk("stall_hold", m_data, saved);
      end
      step(mks(0, 1, 1, 0, 0, dd, 0, 0));
      chk("stall_release_ch0", {240'b0, m_data[0 +: DW]}, {240'b0, dd[0 +: DW]});
      step(mks(0, 0, 1, 0, 0, '0, 0, 0));

      // commit with a write, coinciding with an accept
      step(mks(1, 0, 0, 0, 0, '0, 0, 0));
      step(mks(0, 0, 1, 0, 1, '0, 0, 0));
      for (int i = 0; i < 10; i++) step(mks(0, 1, 1, 0, 0, rnd_data(), 0, 0));
      dd = rnd_data();
      step(mks(0, 1, 1, 1, 1, dd, 2, 7));
      chk("commit_same_old_d", {240'b0, m_data[2*DW +: DW]}, {240'b0, dd[2*DW +: DW]});
      step(mks(0, 1, 1, 0, 0, rnd_data(), 0, 0));
      hn = hist.size();
      h = hist[hn-1-7];
      chk("commit_next_d7", {240'b0, m_data[2*DW +: DW]}, {240'b0, h[2*DW +: DW]});

`ifdef BEAM_DELAY_SUM_EN
      step(mks(1, 0, 0, 0, 0, '0, 0, 0));
      step(mks(0, 0, 1, 0, 1, '0, 0, 0));
      step(mks(0, 1, 1, 0, 0, splat(32'h7FFF), 0, 0));
      chk("sum_full_scale", {236'b0, m_sum}, {236'b0, 20'h7FFF0});
`endif

      // randomized traffic against the model
      step(mks(1, 0, 0, 0, 0, '0, 0, 0));
      for (int i = 0; i < 3000; i++) begin
         st = mks($urandom_range(0, 699) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 39) == 0,
                  rnd_data(),
                  $urandom_range(0, NC-1),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, MD-1) : $urandom_range(0, 20));
         step(st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
